// File: rtl/cobs_pkg.sv
// COBS framing constants and encoder state type, shared by the encode and decode sides of the host link.
package cobs_pkg;
    localparam int         COBS_MAX_RUN    = 254;
    localparam logic [7:0] COBS_DELIM      = 8'h00;
    localparam logic [7:0] COBS_EMPTY_CODE = 8'h01;

    typedef enum logic [2:0] {
        COLLECT,
        SEND_CODE,
        SEND_DATA,
        SEND_TAIL,
        SEND_DELIM
    } enc_state_t;
endpackage

// File: rtl/cobs_group_buf.sv
// Single COBS group store: synchronous write, registered read.
// A read of the address being written returns the new byte.
module cobs_group_buf
    import cobs_pkg::*;
#(
    parameter int DEPTH  = COBS_MAX_RUN,
    parameter int DATA_W = 8,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH))
            r_mem[waddr] <= wdata;
        // Write-first bypass lets a one-byte group be read back the cycle it closes
        if (we && (waddr == raddr))
            r_rdata <= wdata;
        else if (int'(raddr) < DEPTH)
            r_rdata <= r_mem[raddr];
        else
            r_rdata <= '0;
    end

    assign rdata = r_rdata;
endmodule

// File: rtl/cobs_frame_encoder.sv
// COBS frame encoder: buffers one group, then emits code, data and the 0x00 delimiter.
// Optional frame counter output enabled by defining COBS_FRAME_CNT_EN.
//
// state      | meaning
// COLLECT    | accepting raw bytes into the group buffer
// SEND_CODE  | presenting the group code byte
// SEND_DATA  | presenting buffered group bytes
// SEND_TAIL  | presenting 0x01 for a frame that ended on a zero
// SEND_DELIM | presenting the 0x00 frame delimiter
module cobs_frame_encoder
    import cobs_pkg::*;
#(
    parameter int MAX_RUN = COBS_MAX_RUN,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
`ifdef COBS_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);
    localparam int CNT_W = $clog2(MAX_RUN + 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    enc_state_t        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_rptr;
    logic              r_tail;
    logic              r_delim;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_busy;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_nz;
    logic              w_we;
    logic              w_close;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_code;
    logic [CNT_W-1:0]  w_rptr_nxt;
    logic [DATA_W-1:0] w_rdata;
    enc_state_t        w_after_state;
    logic [DATA_W-1:0] w_after_data;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_nz       = (in_data != '0);
    assign w_we       = w_in_xfer && w_nz;
    assign w_cnt_nxt  = r_count + CNT_W'(w_nz);
    assign w_close    = !w_nz || (w_cnt_nxt == CNT_W'(MAX_RUN)) || in_last;
    assign w_code     = DATA_W'(w_cnt_nxt + ONE);

    // Read pointer runs one byte ahead of out_data so the registered read is ready on transfer
    always_comb begin
        w_rptr_nxt = r_rptr;
        if (w_out_xfer) begin
            if (r_state == SEND_CODE && r_count != '0)
                w_rptr_nxt = r_rptr + ONE;
            else if (r_state == SEND_DATA)
                w_rptr_nxt = (r_rptr < r_count) ? r_rptr + ONE : '0;
        end
    end

    always_comb begin
        w_after_state = COLLECT;
        w_after_data  = COBS_DELIM;
        if (r_tail) begin
            w_after_state = SEND_TAIL;
            w_after_data  = COBS_EMPTY_CODE;
        end else if (r_delim) begin
            w_after_state = SEND_DELIM;
        end
    end

    cobs_group_buf #(
        .DEPTH  (MAX_RUN),
        .DATA_W (DATA_W),
        .AW     (CNT_W)
    ) u_buf (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_count),
        .wdata (in_data),
        .raddr (w_rptr_nxt),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= COLLECT;
            r_count     <= '0;
            r_rptr      <= '0;
            r_tail      <= 1'b0;
            r_delim     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_rptr <= w_rptr_nxt;
            case (r_state)
                COLLECT: begin
                    r_in_ready <= 1'b1;
                    if (w_in_xfer) begin
                        r_busy  <= 1'b1;
                        r_count <= w_cnt_nxt;
                        if (w_close) begin
                            r_tail      <= in_last && !w_nz;
                            r_delim     <= in_last;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_code;
                            r_state     <= SEND_CODE;
                        end
                    end
                end
                SEND_CODE: begin
                    if (w_out_xfer) begin
                        if (r_count != '0) begin
                            r_out_data <= w_rdata;
                            r_state    <= SEND_DATA;
                        end else begin
                            r_state <= w_after_state;
                            if (w_after_state == COLLECT) begin
                                r_out_valid <= 1'b0;
                                r_in_ready  <= 1'b1;
                            end else begin
                                r_out_data <= w_after_data;
                            end
                        end
                    end
                end
                SEND_DATA: begin
                    if (w_out_xfer) begin
                        if (r_rptr < r_count) begin
                            r_out_data <= w_rdata;
                        end else begin
                            r_count <= '0;
                            r_state <= w_after_state;
                            if (w_after_state == COLLECT) begin
                                r_out_valid <= 1'b0;
                                r_in_ready  <= 1'b1;
                            end else begin
                                r_out_data <= w_after_data;
                            end
                        end
                    end
                end
                SEND_TAIL: begin
                    if (w_out_xfer) begin
                        r_out_data <= COBS_DELIM;
                        r_state    <= SEND_DELIM;
                    end
                end
                SEND_DELIM: begin
                    if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

`ifdef COBS_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_frame_cnt <= '0;
        else if (r_state == SEND_DELIM && w_out_xfer)
            r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
endmodule

// File: doc/cobs_frame_encoder.md
Name: cobs_frame_encoder

Overview:
- COBS-encodes a byte stream, one frame at a time, for UART transmit back to the host.
- This is the encode side of the host link; the framebuffer loader decodes the same COBS framing on receive.
- Sits between a framebuffer/status readback source and the UART transmitter.
- Buffers up to one COBS group internally, then emits code byte, group data and the 0x00 frame delimiter over a valid/ready stream.

Parameters:
MAX_RUN, 254, maximum non-zero bytes per COBS group (code byte 0xFF); fixed by the protocol, not meant to be changed.
DATA_W, 8, byte width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  input byte valid
in_ready  out  1  encoder accepts input byte this cycle
in_data  in  8  raw frame byte (zero allowed)
in_last  in  1  byte is last of frame
out_valid  out  1  encoded byte valid
out_ready  in  1  UART transmitter accepts encoded byte
out_data  out  8  encoded byte or 0x00 delimiter
busy  out  1  high from first accepted byte of a frame until its delimiter is accepted

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous, active-low. On reset, all state is cleared immediately:
  - in_ready=0, out_valid=0, out_data=0, busy=0.
  - count=0, state=COLLECT.
  - A partially received or partially sent frame is dropped.
  - in_ready rises on the first clock after reset is released.
- Handshakes: an input transfer occurs when in_valid&&in_ready; an output transfer when out_valid&&out_ready.
  - While out_valid=1 and out_ready=0, out_data is held stable.
  - in_ready=1 only in COLLECT.
- State machine: COLLECT, SEND_CODE, SEND_DATA, SEND_TAIL, SEND_DELIM.
  - COLLECT: on an accepted byte:
    - Non-zero byte: write it into buffer[count], count++.
    - Close the group when any of these holds:
      - the byte is zero (the zero is not stored);
      - count reaches MAX_RUN;
      - in_last=1.
    - On close: latch code = count+1 (0xFF when count=254), latch the tail and delim flags, go to SEND_CODE.
  - SEND_CODE: out_valid=1, out_data=code. On transfer, go to SEND_DATA if count>0, else SEND_TAIL/SEND_DELIM/COLLECT.
  - SEND_DATA: emits buffer[0..count-1], with a read pointer advancing once per transfer. After the last data byte:
    - go to SEND_TAIL if tail_flag, else SEND_DELIM if delim_flag, else COLLECT;
    - count clears on leaving.
  - SEND_TAIL: emits 0x01 (empty final group). Used only when the frame's last byte was zero. Then go to SEND_DELIM.
  - SEND_DELIM: emits 0x00. On transfer, clear busy and go to COLLECT.
- Latency: out_valid asserts on the clock edge after the group-closing byte is accepted (1 cycle). Throughput is then one byte per cycle while out_ready=1.
- Boundary cases:
  - A 254-byte non-zero run closes with 0xFF and implies no zero.
  - If that same run ends the frame, no extra 0x01 is sent.
  - A zero immediately after a 0xFF group yields code 0x01.
  - A frame of a single byte with in_last=1 is valid. Empty frames cannot be expressed.
- out_data never carries 0x00 except in SEND_DELIM.

Optional Feature:
- Macro COBS_FRAME_CNT_EN. When defined:
  - adds output frame_cnt[15:0], reset 0;
  - frame_cnt increments on each accepted delimiter and wraps 0xFFFF->0.
- When undefined: the port and counter are absent, with identical encode behaviour.

Decomposition:
- Package cobs_pkg holds:
  - COBS_MAX_RUN=254, COBS_DELIM=8'h00, COBS_EMPTY_CODE=8'h01;
  - the encoder state enum (COLLECT, SEND_CODE, SEND_DATA, SEND_TAIL, SEND_DELIM). The decoder shares the constants.
- Sub-module cobs_group_buf: 254x8 register/BRAM buffer with write port (we, waddr) and read port (raddr, rdata). Keep registered read in mind: the read pointer is pre-advanced so rdata is ready when SEND_DATA presents the byte.

Test Plan:
- Frame 11 22 33 (last on 33), out_ready=1 -> out stream 04 11 22 33 00. busy falls after 00. in_ready=0 from cycle after 33 until 00 accepted.
- Frame 00 (last) -> 01 01 00. Frame 11 00 22 -> 02 11 02 22 00. Frame 11 22 00 (last on 00) -> 03 11 22 01 00.
- 254 bytes 01..FE, last on FE -> FF 01..FE 00 (no 01 before delimiter). 255 bytes 01..FF -> FF 01..FE 02 FF 00.
- Frame 11 22 33 with out_ready toggling pseudo-randomly -> same stream 04 11 22 33 00. out_data stable while out_valid&&!out_ready. No duplicated or dropped bytes.
- rst driven low asynchronously mid SEND_DATA -> out_valid, busy and in_ready go 0 without a clock edge. After release, frame AA last -> 02 AA 00.
- With COBS_FRAME_CNT_EN: three back-to-back frames -> frame_cnt 0->1->2->3, each increment on delimiter acceptance. Preset to 0xFFFF -> wraps to 0.
